multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS-subset CPU. Sequences one instruction over 3–5+ cycles through fetch, decode, execute, memory and writeback. Drives the shared ALU (3-bit ALUOp class to the ALU control decoder), PC/IR write enables, register-file controls and a single unified memory port with a ready handshake. A memory wait-timeout aborts a stalled access.

Parameters:
TIMEOUT, 255, max consecutive cycles waiting on mem_ready_i before abort; 0 disables timeout
CNT_W, 8, width of wait counter; must hold TIMEOUT

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
op_i  in  6  opcode from instruction register (stable after FETCH)
zero_i  in  1  ALU zero flag (used only by PC logic; informational)
mem_ready_i  in  1  memory completes current access this cycle
mem_req_o  out  1  memory access request
mem_we_o  out  1  write (1) / read (0)
iord_o  out  1  address source: 0=PC, 1=ALUOut
ir_write_o  out  1  latch instruction register
pc_write_o  out  1  unconditional PC write
pc_write_cond_o  out  1  PC write if zero_i
pc_src_o  out  2  00=ALU, 01=ALUOut, 10=jump target
alu_src_a_o  out  1  0=PC, 1=reg A
alu_src_b_o  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_op_o  out  3  100=R-type(funct), 000=add, 001=sub, 010=or
reg_write_o  out  1  register file write
reg_dst_o  out  1  1=rd, 0=rt
mem_to_reg_o  out  1  1=memory data, 0=ALUOut
instr_done_o  out  1  one-cycle pulse on last cycle of each instruction
illegal_o  out  1  one-cycle pulse, unsupported opcode in DECODE
bus_err_o  out  1  one-cycle pulse on memory timeout
state_o  out  4  current state (debug)

Behaviour:
- Reset (rst_i=0, async): state=IDLE, wait counter=0; all outputs 0. IDLE -> FETCH unconditionally next cycle.
- Outputs Moore-decoded from state, except ir_write_o/pc_write_o in FETCH, which are qualified by mem_ready_i. Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0, a=0, b=01, alu_op=000, pc_src=00. On mem_ready_i: ir_write=1, pc_write=1, -> DECODE. Otherwise stay.
- DECODE: a=0, b=11, alu_op=000 (branch target into ALUOut). Dispatch on op_i:
  - 000000 -> EXEC_R
  - 001000 (addi) / 001101 (ori) -> EXEC_I
  - 100011 / 101011 (lw/sw) -> MEMADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - other -> FETCH with illegal_o=1 and instr_done_o=1
- EXEC_R: a=1, b=00, alu_op=100 -> WB_R.
- EXEC_I: a=1, b=10, alu_op=000 (addi) or 010 (ori) -> WB_I.
- MEMADDR: a=1, b=10, alu_op=000 -> MEM_RD (lw) or MEM_WR (sw).
- BRANCH: a=1, b=00, alu_op=001, pc_write_cond=1, pc_src=01, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1 -> FETCH.
- MEM_RD: mem_req=1, iord=1. On ready -> WB_MEM.
- MEM_WR: mem_req=1, we=1, iord=1. On ready: instr_done=1 -> FETCH.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- Zero-wait latencies (cycles): R/addi/ori/sw = 4; lw = 5; beq/j = 3.
- mem_req_o and all address/we outputs held stable until the ready cycle; the ready cycle is the last cycle of the request.
- Wait counter:
  - Cleared on every state transition.
  - Increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready_i=0.
  - When counter==TIMEOUT-1 and still not ready: bus_err_o=1, -> FETCH, no PC/IR/reg write. Abort from FETCH re-fetches the same PC.
  - Ready on the same cycle as timeout: ready wins, no error.
  - TIMEOUT=0: never abort.
- Reset asserted mid-instruction: immediate return to IDLE; no partial writes after the reset edge.

Decomposition:
- Package multicycle_pkg: state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEMADDR, MEM_RD, MEM_WR, BRANCH, JUMP, WB_R, WB_I, WB_MEM; 4-bit), opcode constants, ALUOp class constants, alu_src_b/pc_src encodings.
- Sub-module mem_wait_timer (clear, count-enable, expire output; parameters TIMEOUT, CNT_W).

Test Plan:
- Reset then op_i=000000, mem_ready_i=1 always -> states IDLE,FETCH,DECODE,EXEC_R,WB_R; alu_op=100 in EXEC_R; reg_write=1 & reg_dst=1 in WB_R; instr_done pulses at cycle 4 after FETCH entry.
- op_i=100011, mem_ready_i low 3 cycles in MEM_RD -> mem_req/iord held 4 cycles, then WB_MEM with mem_to_reg=1; total 8 cycles.
- op_i=000100 -> BRANCH with alu_op=001, pc_write_cond=1, pc_src=01; op_i=000010 -> pc_write=1, pc_src=10; each 3 cycles.
- op_i=111111 -> illegal_o and instr_done_o pulse in DECODE, next state FETCH, no reg/PC write.
- TIMEOUT=4, mem_ready_i stuck 0 in MEM_WR -> bus_err_o pulses after 4 cycles in MEM_WR, then FETCH; ready arriving exactly on 4th cycle -> no error.
- rst_i dropped asynchronously during MEM_RD -> all outputs 0 immediately, state_o=IDLE; resumes FETCH one cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU main controller.
package multicycle_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    EXEC_I  = 4'd4,
    MEMADDR = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WR  = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    WB_R    = 4'd10,
    WB_I    = 4'd11,
    WB_MEM  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_OR    = 3'b010;
  localparam logic [2:0] ALUOP_FUNCT = 3'b100;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Purely state-decoded (Moore) control bundle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       done;
  } ctrl_t;

  // Moore controls for a state; op only selects the ALU class in EXEC_I.
  function automatic ctrl_t state_ctrl(state_e s, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      end
      MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REGB;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PCSRC_ALUOUT;
        c.done          = 1'b1;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
        c.done     = 1'b1;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      WB_I: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_ctrl_if;
  logic [5:0] op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       iord_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic [1:0] pc_src_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       reg_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       instr_done_o;
  logic       illegal_o;
  logic       bus_err_o;
  logic [3:0] state_o;

  modport master (
    input  op_i, zero_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
           pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
           mem_to_reg_o, instr_done_o, illegal_o, bus_err_o, state_o
  );

  modport slave (
    output op_i, zero_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
           pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
           mem_to_reg_o, instr_done_o, illegal_o, bus_err_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait cycles; expire_o flags the last allowed one.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam bit              ENABLED = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST   = ENABLED ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so every state change starts a fresh wait window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multicycle_ctrl_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   mem_wait, expire, abort, illegal, timer_clr;
  logic   unused_zero;

  // The zero flag is consumed by the PC logic, not by the sequencer.
  assign unused_zero = bus.zero_i;

  assign mem_wait = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !bus.mem_ready_i;

  // Next-state selection; a wait timeout overrides everything and re-fetches.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (bus.mem_ready_i) state_d = DECODE;
      DECODE: begin
        case (bus.op_i)
          OP_RTYPE:        state_d = EXEC_R;
          OP_ADDI, OP_ORI: state_d = EXEC_I;
          OP_LW, OP_SW:    state_d = MEMADDR;
          OP_BEQ:          state_d = BRANCH;
          OP_J:            state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      EXEC_R:  state_d = WB_R;
      EXEC_I:  state_d = WB_I;
      MEMADDR: state_d = (bus.op_i == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:  if (bus.mem_ready_i) state_d = WB_MEM;
      MEM_WR:  if (bus.mem_ready_i) state_d = FETCH;
      BRANCH, JUMP, WB_R, WB_I, WB_MEM: state_d = FETCH;
      default: state_d = IDLE;
    endcase
    if (mem_wait && expire) begin
      abort   = 1'b1;
      state_d = FETCH;
    end
  end

  // State plus Moore controls registered from the next state, so the
  // decoded outputs are glitch-free yet still line up with state_q.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, bus.op_i);
    end
  end

  // Abort from FETCH loops back to FETCH, so it must clear explicitly.
  assign timer_clr = (state_d != state_q) || abort;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clr),
    .en_i     (mem_wait),
    .expire_o (expire)
  );

  assign bus.mem_req_o       = ctrl_q.mem_req;
  assign bus.mem_we_o        = ctrl_q.mem_we;
  assign bus.iord_o          = ctrl_q.iord;
  assign bus.pc_write_cond_o = ctrl_q.pc_write_cond;
  assign bus.pc_src_o        = ctrl_q.pc_src;
  assign bus.alu_src_a_o     = ctrl_q.alu_src_a;
  assign bus.alu_src_b_o     = ctrl_q.alu_src_b;
  assign bus.alu_op_o        = ctrl_q.alu_op;
  assign bus.reg_write_o     = ctrl_q.reg_write;
  assign bus.reg_dst_o       = ctrl_q.reg_dst;
  assign bus.mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign bus.state_o         = state_q;

  // Ready-qualified and pulse outputs follow the live inputs.
  assign bus.ir_write_o   = (state_q == FETCH) && bus.mem_ready_i;
  assign bus.pc_write_o   = ctrl_q.pc_write || ((state_q == FETCH) && bus.mem_ready_i);
  assign bus.instr_done_o = ctrl_q.done || illegal ||
                            ((state_q == MEM_WR) && bus.mem_ready_i);
  assign bus.illegal_o    = illegal;
  assign bus.bus_err_o    = abort;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed literal checks plus randomized
// traffic compared every cycle against an instruction-plan model.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4,
                 S_MEMADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_BRANCH = 8, S_JUMP = 9,
                 S_WB_R = 10, S_WB_I = 11, S_WB_MEM = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Model state: current state, remaining steps of the instruction, wait count.
  int m_cur = S_IDLE;
  int plan[$];
  int m_wait = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] expect_vec(input int cur, input logic [5:0] op,
      input logic rdy, input logic to, input logic done, input logic ill);
    logic req, we, iord, irw, pcw, pcwc, srca, regw, regdst, m2r;
    logic [1:0] pcsrc, srcb;
    logic [2:0] aluop;
    {req, we, iord, pcwc, srca, regw, regdst, m2r} = '0;
    pcsrc = 2'b00; srcb = 2'b00; aluop = 3'b000;
    case (cur)
      S_FETCH:   begin req = 1; srcb = 2'b01; end
      S_DECODE:  srcb = 2'b11;
      S_EXEC_R:  begin srca = 1; aluop = 3'b100; end
      S_EXEC_I:  begin srca = 1; srcb = 2'b10; aluop = (op == 6'b001101) ? 3'b010 : 3'b000; end
      S_MEMADDR: begin srca = 1; srcb = 2'b10; end
      S_BRANCH:  begin srca = 1; aluop = 3'b001; pcwc = 1; pcsrc = 2'b01; end
      S_JUMP:    pcsrc = 2'b10;
      S_MEM_RD:  begin req = 1; iord = 1; end
      S_MEM_WR:  begin req = 1; we = 1; iord = 1; end
      S_WB_R:    begin regw = 1; regdst = 1; end
      S_WB_I:    regw = 1;
      S_WB_MEM:  begin regw = 1; m2r = 1; end
      default: ;
    endcase
    irw = (cur == S_FETCH) && rdy;
    pcw = (cur == S_JUMP) || irw;
    return {4'(cur), req, we, iord, irw, pcw, pcwc, pcsrc, srca, srcb, aluop,
            regw, regdst, m2r, done, ill, to};
  endfunction

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin : cmp
    logic [23:0] act, exp;
    logic is_mem, to, adv, ill, done;
    int nxt;
    act = {bus.state_o, bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.ir_write_o,
           bus.pc_write_o, bus.pc_write_cond_o, bus.pc_src_o, bus.alu_src_a_o,
           bus.alu_src_b_o, bus.alu_op_o, bus.reg_write_o, bus.reg_dst_o,
           bus.mem_to_reg_o, bus.instr_done_o, bus.illegal_o, bus.bus_err_o};
    if (!rst_n) begin
      n_chk++;
      if (act !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_outputs t=%0t: got %h want 000000", $time, act);
      end
      m_cur = S_IDLE; plan.delete(); m_wait = 0;
    end else begin
      is_mem = (m_cur == S_FETCH) || (m_cur == S_MEM_RD) || (m_cur == S_MEM_WR);
      to  = is_mem && !bus.mem_ready_i && (m_wait == TO - 1);
      adv = !is_mem || bus.mem_ready_i;
      ill = 1'b0;
      if (to) begin
        plan.delete();
        nxt = S_FETCH;
      end else if (adv) begin
        if (m_cur == S_FETCH) plan.push_back(S_DECODE);
        else if (m_cur == S_DECODE) begin
          case (bus.op_i)
            6'b000000: begin plan.push_back(S_EXEC_R); plan.push_back(S_WB_R); end
            6'b001000, 6'b001101: begin plan.push_back(S_EXEC_I); plan.push_back(S_WB_I); end
            6'b100011: begin plan.push_back(S_MEMADDR); plan.push_back(S_MEM_RD); plan.push_back(S_WB_MEM); end
            6'b101011: begin plan.push_back(S_MEMADDR); plan.push_back(S_MEM_WR); end
            6'b000100: plan.push_back(S_BRANCH);
            6'b000010: plan.push_back(S_JUMP);
            default: ill = 1'b1;
          endcase
        end
        nxt = (plan.size() != 0) ? plan.pop_front() : S_FETCH;
      end else nxt = m_cur;
      // The last cycle of an instruction is any completing cycle that returns to FETCH.
      done = !to && adv && (nxt == S_FETCH) && (m_cur != S_IDLE) && (m_cur != S_FETCH);
      exp = expect_vec(m_cur, bus.op_i, bus.mem_ready_i, to, done, ill);
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t state=%0d: got %h want %h", $time, m_cur, act, exp);
      end
      if (nxt != m_cur || to) m_wait = 0;
      else if (is_mem && !bus.mem_ready_i) m_wait = m_wait + 1;
      m_cur = nxt;
    end
  end

  // Directed run: sp holds n state nibbles, rp holds n ready bits, both left to right.
  task automatic run_dir(input string nm, input logic [5:0] op, input int n,
      input logic [7:0] rp, input logic [31:0] sp, output int done_at, output int ill_at,
      output int err_at, output int iord_cnt, output int pcsrc_done);
    done_at = -1; ill_at = -1; err_at = -1; iord_cnt = 0; pcsrc_done = -1;
    for (int i = 0; i < n; i++) begin
      bus.op_i = op;
      bus.mem_ready_i = rp[n-1-i];
      bus.zero_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("%s_state%0d", nm, i), int'(bus.state_o), int'(sp[(n-1-i)*4 +: 4]));
      if (bus.instr_done_o) begin done_at = i; pcsrc_done = int'(bus.pc_src_o); end
      if (bus.illegal_o) ill_at = i;
      if (bus.bus_err_o) err_at = i;
      if (bus.mem_req_o && bus.iord_o) iord_cnt++;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b001000;
      2: return 6'b001101;
      3: return 6'b100011;
      4: return 6'b101011;
      5: return 6'b000100;
      6: return 6'b000010;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    int d, il, e, ic, ps, pct;
    bus.op_i = 6'b000000; bus.mem_ready_i = 1'b1; bus.zero_i = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", int'(bus.state_o), S_IDLE);
    chk("reset_mem_req", int'(bus.mem_req_o), 0);
    rst_n = 1'b1;

    run_dir("rtype", 6'b000000, 5, 8'b11111, 32'h0123A, d, il, e, ic, ps);
    chk("rtype_done_at", d, 4);
    run_dir("lw_wait", 6'b100011, 8, 8'b11100011, 32'h1256666C, d, il, e, ic, ps);
    chk("lw_done_at", d, 7);
    chk("lw_iord_cycles", ic, 4);
    run_dir("beq", 6'b000100, 3, 8'b111, 32'h128, d, il, e, ic, ps);
    chk("beq_done_at", d, 2);
    chk("beq_pc_src", ps, 1);
    run_dir("j", 6'b000010, 3, 8'b111, 32'h129, d, il, e, ic, ps);
    chk("j_done_at", d, 2);
    chk("j_pc_src", ps, 2);
    run_dir("illegal", 6'b111111, 2, 8'b11, 32'h12, d, il, e, ic, ps);
    chk("illegal_at", il, 1);
    chk("illegal_done_at", d, 1);
    run_dir("sw_timeout", 6'b101011, 8, 8'b11100000, 32'h12577771, d, il, e, ic, ps);
    chk("sw_timeout_err_at", e, 6);
    chk("sw_timeout_no_done", d, -1);
    run_dir("sw_late_ready", 6'b101011, 7, 8'b1110001, 32'h1257777, d, il, e, ic, ps);
    chk("sw_late_no_err", e, -1);
    chk("sw_late_done_at", d, 6);

    run_dir("lw_reset", 6'b100011, 4, 8'b1110, 32'h1256, d, il, e, ic, ps);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_state", int'(bus.state_o), S_IDLE);
    chk("midreset_req_iord", int'({bus.mem_req_o, bus.iord_o}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.op_i = 6'b000000;
    run_dir("recover", 6'b000000, 2, 8'b11, 32'h01, d, il, e, ic, ps);

    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 4)
        0: pct = 100;
        1: pct = 70;
        2: pct = 30;
        default: pct = 8;
      endcase
      rst_n = ($urandom_range(0, 399) != 0);
      if (m_cur == S_FETCH || m_cur == S_IDLE) bus.op_i = pick_op();
      bus.mem_ready_i = ($urandom_range(0, 99) < pct);
      bus.zero_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
